fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation core, replacing the single-register PC plus combinational instruction-memory read. Issues pipelined, in-order requests to an instruction memory of arbitrary latency, buffers returned instructions with their PC in a queue, and hands them to decode over a valid/ready handshake. Branch redirects from branch control flush the queue and discard in-flight responses.

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: pipelined imem requests, PC-tagged queue, redirect flush.
// Optional FETCH_BYPASS_EN: forward a response straight to decode when the queue is empty.
module fetch_unit #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              QUEUE_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [31:0]     data_q [QUEUE_DEPTH];
  logic [XLEN-1:0] pc_q   [QUEUE_DEPTH];
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  cnt_t            count_q, count_d;
  cnt_t            outst_q, outst_d;
  cnt_t            drop_q, drop_d;
  logic [XLEN-1:0] redir_pc;
  logic [CW:0]     inflight;
  logic            issue;
  logic            resp_keep;
  logic            q_push;
  logic            q_pop;
  logic [1:0]      unused_redir_lsb;

  assign unused_redir_lsb = redirect_pc[1:0];
  assign redir_pc  = {redirect_pc[XLEN-1:2], 2'b00};
  // Queue slots are reserved at issue time, so a kept response always fits.
  assign inflight  = {1'b0, count_q} + {1'b0, outst_q};
  assign issue     = rst_n & ~redirect_valid
                   & (inflight < (CW+1)'(QUEUE_DEPTH));
  assign resp_keep = rst_n & imem_rvalid & ~redirect_valid
                   & (drop_q == '0);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
  logic byp;
  assign byp         = resp_keep & (count_q == '0);
  assign instr_valid = (count_q != '0) | byp;
  assign instr_data  = byp ? imem_rdata : data_q[rd_ptr_q];
  assign instr_pc    = byp ? resp_pc_q : pc_q[rd_ptr_q];
  assign q_push      = resp_keep & ~(byp & instr_ready);
  assign q_pop       = instr_valid & instr_ready & ~byp;
`else
  assign instr_valid = count_q != '0;
  assign instr_data  = data_q[rd_ptr_q];
  assign instr_pc    = pc_q[rd_ptr_q];
  assign q_push      = resp_keep;
  assign q_pop       = instr_valid & instr_ready;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    outst_d    = outst_q + cnt_t'(issue) - cnt_t'(imem_rvalid);
    if (issue) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (redirect_valid) begin
      fetch_pc_d = redir_pc;
      resp_pc_d  = redir_pc;
      drop_d     = outst_q - cnt_t'(imem_rvalid);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_rvalid && drop_q != '0) begin
        drop_d = drop_q - cnt_t'(1);
      end
      if (resp_keep) begin
        resp_pc_d = resp_pc_q + XLEN'(4);
      end
      if (q_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (q_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + cnt_t'(q_push) - cnt_t'(q_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= RESET_PC;
      end
    end else if (q_push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pc_q[wr_ptr_q]   <= resp_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order fixed-latency imem model.
// Memory data = address ^ K so PC and data paths are distinguishable.
module tb_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  localparam logic [31:0] K = 32'h5A00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b1;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(32), .RESET_PC(32'h0), .QUEUE_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  int lat = 1;
  int cyc = 0;
  logic [31:0] mq_a[$];
  int mq_t[$];

  // Memory: records requests at +2, answers exactly lat cycles later.
  always @(posedge clk) begin
    #2;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (!rst_n) begin
      mq_a.delete();
      mq_t.delete();
    end else begin
      if (imem_req) begin
        mq_a.push_back(imem_addr);
        mq_t.push_back(cyc + lat);
      end
      if (mq_t.size() != 0 && mq_t[0] == cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq_a[0] ^ K;
        void'(mq_a.pop_front());
        void'(mq_t.pop_front());
      end
    end
  end

  task automatic go(input logic rdy, input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    instr_ready    = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #3;
  endtask

  task automatic restart(input int l, input logic rdy);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = rdy;
    lat = l;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    check({tag, "_v"}, instr_valid, 1'b1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_d"}, instr_data, pc ^ K);
  endtask

  int nreq;
  logic [31:0] epc;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_data", instr_data, 32'h0);
    check("rst_pc", instr_pc, 32'h0);

    // Streaming at latency 1
    restart(1, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) go(1'b1, 1'b0, '0);
      check("s_req", imem_req, 1'b1);
      check("s_addr", imem_addr, 32'(4 * k));
      if (k >= 2 - B) chk_head("s", 32'(4 * (k - 2 + B)));
      else check("s_idle", instr_valid, 1'b0);
    end

    // Decode stalled: exactly QUEUE_DEPTH requests, then drain in order
    restart(1, 1'b0);
    nreq = 0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) go(1'b0, 1'b0, '0);
      if (imem_req) begin
        check("st_addr", imem_addr, 32'(4 * nreq));
        nreq++;
      end
      if (instr_valid) check("st_hold", instr_pc, 32'h0);
    end
    check("st_nreq", 32'(nreq), 32'd4);
    check("st_valid", instr_valid, 1'b1);
    check("st_noreq", imem_req, 1'b0);
    for (int k = 0; k < 8; k++) begin
      go(1'b1, 1'b0, '0);
      chk_head("dr", 32'(4 * k));
    end

    // Latency 3, redirect with three in flight (one arriving now)
    restart(3, 1'b1);
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b1, 32'h103);
    check("r3_req", imem_req, 1'b0);
    check("r3_valid", instr_valid, 1'b0);
    for (int k = 4; k <= 10; k++) begin
      go(1'b1, 1'b0, '0);
      if (k == 4) begin
        check("r3_nreq", imem_req, 1'b1);
        check("r3_naddr", imem_addr, 32'h100);
      end
      if (k < 8 - B) check("r3_drop", instr_valid, 1'b0);
      else chk_head("r3", 32'h100 + 32'(4 * (k - 8 + B)));
    end

    // Latency 2, redirect coincident with a response, two outstanding
    restart(2, 1'b1);
    go(1'b1, 1'b0, '0);
    go(1'b1, 1'b1, 32'h200);
    check("r2_req", imem_req, 1'b0);
    check("r2_valid", instr_valid, 1'b0);
    for (int k = 3; k <= 8; k++) begin
      go(1'b1, 1'b0, '0);
      if (k == 3) check("r2_naddr", imem_addr, 32'h200);
      if (k < 6 - B) check("r2_drop", instr_valid, 1'b0);
      else chk_head("r2", 32'h200 + 32'(4 * (k - 6 + B)));
    end

    // PC wrap at the top of the address space
    restart(1, 1'b1);
    go(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int k = 2; k <= 6; k++) begin
      go(1'b1, 1'b0, '0);
      if (k == 2) check("w_addr0", imem_addr, 32'hFFFF_FFFC);
      if (k == 3) check("w_addr1", imem_addr, 32'h0);
      if (k < 4 - B) check("w_idle", instr_valid, 1'b0);
      else begin
        epc = 32'hFFFF_FFFC + 32'(4 * (k - 4 + B));
        chk_head("w", epc);
      end
    end

    // Reset asserted mid-stream with a partly full queue
    restart(1, 1'b0);
    for (int k = 1; k <= 4; k++) go(1'b0, 1'b0, '0);
    chk_head("mr_pre", 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_valid", instr_valid, 1'b0);
    check("mr_req", imem_req, 1'b0);
    check("mr_addr", imem_addr, 32'h0);
    check("mr_pc", instr_pc, 32'h0);
    check("mr_data", instr_data, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    #3;
    check("mr_req0", imem_req, 1'b1);
    check("mr_addr0", imem_addr, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      go(1'b1, 1'b0, '0);
      if (k >= 2 - B) chk_head("mr", 32'(4 * (k - 2 + B)));
      else check("mr_idle", instr_valid, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
